// File: rtl/wbram_bank_writer_if.sv
// Stream, bank port-A and ping-pong handshake bundle for wbram_bank_writer.
// master: weight source + consumer side; slave: the bank writer itself.
interface wbram_bank_writer_if #(
  parameter int unsigned STREAM_WIDTH = 64,
  parameter int unsigned WBRAM_DEPTH  = 512,
  parameter int unsigned NUM_BANKS    = 4
);
  localparam int unsigned HalfDepth = WBRAM_DEPTH / 2;
  localparam int unsigned AddrW     = $clog2(WBRAM_DEPTH);
  localparam int unsigned WordsW    = $clog2(NUM_BANKS * HalfDepth + 1);

  logic                    s_valid;
  logic                    s_ready;
  logic [STREAM_WIDTH-1:0] s_data;
  logic                    s_last;
  logic [AddrW-1:0]        addrA_o;
  logic [STREAM_WIDTH-1:0] diA_o;
  logic [NUM_BANKS-1:0]    enaA_o;
  logic [NUM_BANKS-1:0]    weA_o;
  logic                    wr_half;
  logic [1:0]              buf_full;
  logic [1:0]              buf_release;
  logic                    buf_done;
  logic                    buf_done_id;
  logic [WordsW-1:0]       buf_words;

  modport master (
    output s_valid, s_data, s_last, buf_release,
    input  s_ready, addrA_o, diA_o, enaA_o, weA_o, wr_half, buf_full,
           buf_done, buf_done_id, buf_words
  );

  modport slave (
    input  s_valid, s_data, s_last, buf_release,
    output s_ready, addrA_o, diA_o, enaA_o, weA_o, wr_half, buf_full,
           buf_done, buf_done_id, buf_words
  );
endinterface

// File: rtl/wbram_bank_writer.sv
// Sequential write front-end for the weight-BRAM banks: walks a word index across
// the banks (bank-major or interleaved), fills ping-pong halves and hands completed
// halves to the consumer through a full/release handshake.
module wbram_bank_writer #(
  parameter int unsigned STREAM_WIDTH = 64,
  parameter int unsigned WBRAM_DEPTH  = 512,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned INTERLEAVE   = 0
) (
  input logic                clk,
  input logic                rst,
  wbram_bank_writer_if.slave bus
);
  localparam int unsigned HalfDepth = WBRAM_DEPTH / 2;
  localparam int unsigned Cap       = NUM_BANKS * HalfDepth;
  localparam int unsigned AddrW     = $clog2(WBRAM_DEPTH);
  localparam int unsigned WordsW    = $clog2(Cap + 1);

  typedef enum logic {StFill, StStall} state_e;

  state_e                  state_q;
  logic [WordsW-1:0]       w_q;
  logic                    half_q;
  logic [1:0]              full_q;
  logic [NUM_BANKS-1:0]    ena_q;
  logic [AddrW-1:0]        addr_q;
  logic [STREAM_WIDTH-1:0] data_q;
  logic                    done_q;
  logic                    done_id_q;
  logic [WordsW-1:0]       words_q;

  logic                 accept;
  logic                 close;
  int unsigned          bank;
  int unsigned          offset;
  logic [AddrW-1:0]     wr_addr;
  logic [NUM_BANKS-1:0] wr_ena;
  logic                 half_d;
  logic [1:0]           full_d;

  // Decode the current word index into a bank strobe/address and work out the
  // post-edge ping-pong bookkeeping.
  always_comb begin
    accept = bus.s_valid && (state_q == StFill);
    close  = accept && ((32'(w_q) == Cap - 1) || bus.s_last);
    if (INTERLEAVE != 0) begin
      bank   = 32'(w_q) % NUM_BANKS;
      offset = 32'(w_q) / NUM_BANKS;
    end else begin
      bank   = 32'(w_q) / HalfDepth;
      offset = 32'(w_q) % HalfDepth;
    end
    wr_addr = AddrW'(32'(half_q) * HalfDepth + offset);
    wr_ena  = NUM_BANKS'(1) << bank;
    half_d  = close ? ~half_q : half_q;
    // Releasing a half that is not full clears an already-clear bit; the filling
    // half is never full, so a close always wins over a same-half release.
    full_d  = full_q & ~bus.buf_release;
    if (close) begin
      full_d[half_q] = 1'b1;
    end
  end

  // Registered write port, word walker, buffer flags and fill/stall FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      w_q       <= '0;
      half_q    <= 1'b0;
      full_q    <= 2'b00;
      ena_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      words_q   <= '0;
    end else begin
      done_q <= close;
      if (accept) begin
        ena_q  <= wr_ena;
        addr_q <= wr_addr;
        data_q <= bus.s_data;
      end else begin
        ena_q  <= '0;
      end
      if (close) begin
        done_id_q <= half_q;
        words_q   <= WordsW'(32'(w_q) + 1);
        w_q       <= '0;
      end else if (accept) begin
        w_q <= w_q + WordsW'(1);
      end
      half_q  <= half_d;
      full_q  <= full_d;
      // Stall whenever the half we are about to fill still holds a buffer.
      state_q <= full_d[half_d] ? StStall : StFill;
    end
  end

  assign bus.s_ready     = (state_q == StFill);
  assign bus.enaA_o      = ena_q;
  assign bus.weA_o       = ena_q;
  assign bus.addrA_o     = addr_q;
  assign bus.diA_o       = data_q;
  assign bus.wr_half     = half_q;
  assign bus.buf_full    = full_q;
  assign bus.buf_done    = done_q;
  assign bus.buf_done_id = done_id_q;
  assign bus.buf_words   = words_q;
endmodule

// File: tb/tb_wbram_bank_writer.sv
// Bench for wbram_bank_writer: one bank-major and one interleaved instance share the
// same stimulus; both are checked every cycle against a word-level reference model,
// plus a hand-derived vector table and directed corner-case sequences.
module tb_wbram_bank_writer;
  localparam int unsigned SW  = 16;
  localparam int unsigned WD  = 8;
  localparam int unsigned NB  = 4;
  localparam int unsigned HD  = WD / 2;
  localparam int unsigned CAP = NB * HD;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_last;
  logic [SW-1:0] s_data;
  logic [1:0]    buf_release;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wbram_bank_writer_if #(.STREAM_WIDTH(SW), .WBRAM_DEPTH(WD), .NUM_BANKS(NB)) bm_if ();
  wbram_bank_writer_if #(.STREAM_WIDTH(SW), .WBRAM_DEPTH(WD), .NUM_BANKS(NB)) il_if ();

  assign bm_if.s_valid     = s_valid;
  assign bm_if.s_data      = s_data;
  assign bm_if.s_last      = s_last;
  assign bm_if.buf_release = buf_release;
  assign il_if.s_valid     = s_valid;
  assign il_if.s_data      = s_data;
  assign il_if.s_last      = s_last;
  assign il_if.buf_release = buf_release;

  wbram_bank_writer #(.STREAM_WIDTH(SW), .WBRAM_DEPTH(WD), .NUM_BANKS(NB), .INTERLEAVE(0))
    u_bm (.clk(clk), .rst(rst), .bus(bm_if));
  wbram_bank_writer #(.STREAM_WIDTH(SW), .WBRAM_DEPTH(WD), .NUM_BANKS(NB), .INTERLEAVE(1))
    u_il (.clk(clk), .rst(rst), .bus(il_if));

  // Reference model: buffer flags, current half and word index, plus the expected
  // registered outputs for the cycle after each edge.
  logic [1:0]    m_full;
  logic          m_half;
  int unsigned   m_w;
  logic [NB-1:0] e_ena_bm, e_ena_il;
  logic [2:0]    e_addr_bm, e_addr_il;
  logic [SW-1:0] e_di;
  logic          e_done, e_id;
  logic [4:0]    e_words;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       v;
    logic       l;
    logic [3:0] ena_bm;
    logic [2:0] addr_bm;
    logic [3:0] ena_il;
    logic [2:0] addr_il;
    logic       done;
    logic [4:0] words;
    logic [1:0] full;
    logic       half;
  } vec_t;

  vec_t tbl [8];
  int   done_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full    = 2'b00;
    m_half    = 1'b0;
    m_w       = 0;
    e_ena_bm  = '0;
    e_ena_il  = '0;
    e_addr_bm = '0;
    e_addr_il = '0;
    e_di      = '0;
    e_done    = 1'b0;
    e_id      = 1'b0;
    e_words   = '0;
  endtask

  task automatic check_outs();
    chk("ena_bm",   64'(bm_if.enaA_o),      64'(e_ena_bm));
    chk("we_bm",    64'(bm_if.weA_o),       64'(e_ena_bm));
    chk("addr_bm",  64'(bm_if.addrA_o),     64'(e_addr_bm));
    chk("di_bm",    64'(bm_if.diA_o),       64'(e_di));
    chk("ena_il",   64'(il_if.enaA_o),      64'(e_ena_il));
    chk("we_il",    64'(il_if.weA_o),       64'(e_ena_il));
    chk("addr_il",  64'(il_if.addrA_o),     64'(e_addr_il));
    chk("di_il",    64'(il_if.diA_o),       64'(e_di));
    chk("done_bm",  64'(bm_if.buf_done),    64'(e_done));
    chk("done_il",  64'(il_if.buf_done),    64'(e_done));
    chk("id_bm",    64'(bm_if.buf_done_id), 64'(e_id));
    chk("id_il",    64'(il_if.buf_done_id), 64'(e_id));
    chk("words_bm", 64'(bm_if.buf_words),   64'(e_words));
    chk("words_il", 64'(il_if.buf_words),   64'(e_words));
    chk("full_bm",  64'(bm_if.buf_full),    64'(m_full));
    chk("full_il",  64'(il_if.buf_full),    64'(m_full));
    chk("half_bm",  64'(bm_if.wr_half),     64'(m_half));
    chk("half_il",  64'(il_if.wr_half),     64'(m_half));
  endtask

  // One clock cycle: drive inputs at the falling edge, check s_ready, advance the
  // model by the same edge, then check all registered outputs after the edge.
  task automatic step(input logic r, input logic v, input logic [SW-1:0] d, input logic l,
                      input logic [1:0] rel);
    logic acc;
    logic cls;
    @(negedge clk);
    rst         = r;
    s_valid     = v;
    s_data      = d;
    s_last      = l;
    buf_release = rel;
    #1;
    chk("s_ready_bm", 64'(bm_if.s_ready), 64'(!m_full[m_half]));
    chk("s_ready_il", 64'(il_if.s_ready), 64'(!m_full[m_half]));
    if (r) begin
      model_reset();
    end else begin
      acc = v && !m_full[m_half];
      if (acc) begin
        e_ena_bm  = NB'(1) << (m_w / HD);
        e_addr_bm = 3'(m_half * HD + m_w % HD);
        e_ena_il  = NB'(1) << (m_w % NB);
        e_addr_il = 3'(m_half * HD + m_w / NB);
        e_di      = d;
      end else begin
        e_ena_bm = '0;
        e_ena_il = '0;
      end
      // A release frees a half only if that half actually holds a buffer.
      for (int h = 0; h < 2; h++) begin
        if (rel[h] && m_full[h]) m_full[h] = 1'b0;
      end
      cls    = acc && (m_w == CAP - 1 || l);
      e_done = cls;
      if (cls) begin
        m_full[m_half] = 1'b1;
        e_id           = m_half;
        e_words        = 5'(m_w + 1);
        m_half         = !m_half;
        m_w            = 0;
      end else if (acc) begin
        m_w = m_w + 1;
      end
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  initial begin
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    buf_release = 2'b00;
    model_reset();

    // Hand-derived vectors: six words with s_last on the sixth, then one word into
    // half 1, then an idle cycle.
    tbl[0] = '{1'b1, 1'b0, 4'h1, 3'd0, 4'h1, 3'd0, 1'b0, 5'd0, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'h1, 3'd1, 4'h2, 3'd0, 1'b0, 5'd0, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'h1, 3'd2, 4'h4, 3'd0, 1'b0, 5'd0, 2'b00, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'h1, 3'd3, 4'h8, 3'd0, 1'b0, 5'd0, 2'b00, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'h2, 3'd0, 4'h1, 3'd1, 1'b0, 5'd0, 2'b00, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'h2, 3'd1, 4'h2, 3'd1, 1'b1, 5'd6, 2'b01, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 4'h1, 3'd4, 4'h1, 3'd4, 1'b0, 5'd6, 2'b01, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 3'd4, 4'h0, 3'd4, 1'b0, 5'd6, 2'b01, 1'b1};

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena",   64'(bm_if.enaA_o),      64'(0));
    chk("rst_we",    64'(il_if.weA_o),       64'(0));
    chk("rst_addr",  64'(bm_if.addrA_o),     64'(0));
    chk("rst_di",    64'(il_if.diA_o),       64'(0));
    chk("rst_full",  64'(bm_if.buf_full),    64'(0));
    chk("rst_done",  64'(bm_if.buf_done),    64'(0));
    chk("rst_id",    64'(bm_if.buf_done_id), 64'(0));
    chk("rst_words", 64'(bm_if.buf_words),   64'(0));
    chk("rst_half",  64'(bm_if.wr_half),     64'(0));
    chk("rst_ready", 64'(bm_if.s_ready),     64'(1));

    // Early close via table.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].v, SW'(16'h100 + i), tbl[i].l, 2'b00);
      chk($sformatf("tbl%0d_ena_bm", i),  64'(bm_if.enaA_o),    64'(tbl[i].ena_bm));
      chk($sformatf("tbl%0d_addr_bm", i), 64'(bm_if.addrA_o),   64'(tbl[i].addr_bm));
      chk($sformatf("tbl%0d_ena_il", i),  64'(il_if.enaA_o),    64'(tbl[i].ena_il));
      chk($sformatf("tbl%0d_addr_il", i), 64'(il_if.addrA_o),   64'(tbl[i].addr_il));
      chk($sformatf("tbl%0d_done", i),    64'(bm_if.buf_done),  64'(tbl[i].done));
      chk($sformatf("tbl%0d_words", i),   64'(bm_if.buf_words), 64'(tbl[i].words));
      chk($sformatf("tbl%0d_full", i),    64'(il_if.buf_full),  64'(tbl[i].full));
      chk($sformatf("tbl%0d_half", i),    64'(il_if.wr_half),   64'(tbl[i].half));
    end

    // Reset mid-fill with a valid word presented: no strobe, flags cleared.
    step(1'b1, 1'b1, SW'(16'h5555), 1'b0, 2'b00);
    chk("mid_rst_ena",  64'(bm_if.enaA_o),   64'(0));
    chk("mid_rst_full", 64'(bm_if.buf_full), 64'(0));
    chk("mid_rst_half", 64'(bm_if.wr_half),  64'(0));
    step(1'b0, 1'b1, SW'(16'hAAAA), 1'b0, 2'b00);
    chk("post_rst_ena_bm",  64'(bm_if.enaA_o),  64'(1));
    chk("post_rst_addr_bm", 64'(bm_if.addrA_o), 64'(0));
    chk("post_rst_ena_il",  64'(il_if.enaA_o),  64'(1));
    chk("post_rst_addr_il", 64'(il_if.addrA_o), 64'(0));
    chk("post_rst_di",      64'(bm_if.diA_o),   64'(16'hAAAA));

    // Back-to-back stream of 32 words from reset: fills both halves.
    step(1'b1, 1'b0, '0, 1'b0, 2'b00);
    done_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 1'b1, SW'(k), 1'b0, 2'b00);
      if (k < 16 && bm_if.buf_done) done_cnt++;
      if (k == 15) begin
        chk("bm16_done_cnt", 64'(done_cnt),           64'(1));
        chk("bm16_id",       64'(bm_if.buf_done_id),  64'(0));
        chk("bm16_words",    64'(bm_if.buf_words),    64'(16));
        chk("bm16_full",     64'(bm_if.buf_full),     64'(2'b01));
        chk("bm16_half",     64'(bm_if.wr_half),      64'(1));
      end
      if (k == 16) begin
        chk("bm17_ena",  64'(bm_if.enaA_o),  64'(1));
        chk("bm17_addr", 64'(bm_if.addrA_o), 64'(4));
      end
      if (k == 17) begin
        chk("il18_ena",  64'(il_if.enaA_o),  64'(4'h2));
        chk("il18_addr", 64'(il_if.addrA_o), 64'(4));
      end
    end
    chk("both_full",    64'(il_if.buf_full), 64'(2'b11));
    chk("both_stalled", 64'(il_if.s_ready),  64'(0));
    step(1'b0, 1'b1, SW'(16'hBEEF), 1'b0, 2'b00);
    chk("stall_no_strobe", 64'(bm_if.enaA_o), 64'(0));

    // Release half 0: ready returns next cycle and refill starts at bank0 addr 0.
    step(1'b0, 1'b0, '0, 1'b0, 2'b01);
    chk("rel_ready", 64'(bm_if.s_ready),  64'(1));
    chk("rel_full",  64'(bm_if.buf_full), 64'(2'b10));
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, SW'(16'h200 + k), 1'b0, 2'b00);
      if (k == 0) begin
        chk("refill_ena_bm",  64'(bm_if.enaA_o),  64'(1));
        chk("refill_addr_bm", 64'(bm_if.addrA_o), 64'(0));
        chk("refill_addr_il", 64'(il_if.addrA_o), 64'(0));
      end
    end
    chk("refill_full", 64'(bm_if.buf_full), 64'(2'b11));

    // Free both halves, then a release of an already-empty half is ignored.
    step(1'b0, 1'b0, '0, 1'b0, 2'b11);
    chk("rel_both_full", 64'(bm_if.buf_full), 64'(2'b00));
    step(1'b0, 1'b0, '0, 1'b0, 2'b01);
    chk("rel_empty_full",  64'(bm_if.buf_full), 64'(2'b00));
    chk("rel_empty_ready", 64'(bm_if.s_ready),  64'(1));

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           SW'($urandom),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
